// File: rtl/imm_pack_pkg.sv
// Shared definitions for the immediate packer: kind codes, field width,
// and the packing function used by the combinational core.
package imm_pack_pkg;

  localparam int VALUE_W = 16;
  localparam int KIND_W  = 3;
  localparam int FIELD_W = 11;

  // Immediate kind codes, identical to the decode-side extender encodings.
  localparam logic [KIND_W-1:0] IM0      = 3'd0;
  localparam logic [KIND_W-1:0] IM3      = 3'd1;
  localparam logic [KIND_W-1:0] IM4      = 3'd2;
  localparam logic [KIND_W-1:0] IM5      = 3'd3;
  localparam logic [KIND_W-1:0] IM8      = 3'd4;
  localparam logic [KIND_W-1:0] IM11     = 3'd5;
  localparam logic [KIND_W-1:0] IM_TO8   = 3'd6;
  localparam logic [KIND_W-1:0] IM_ZERO8 = 3'd7;

  typedef struct packed {
    logic [FIELD_W-1:0] field;
    logic               fits;
  } pack_res_t;

  // Signed n-bit field: fits when sign-extending the low n bits rebuilds v.
  function automatic pack_res_t pack_signed(input logic [VALUE_W-1:0] v,
                                            input int unsigned n,
                                            input logic sat);
    pack_res_t          r;
    logic [VALUE_W-1:0] mask;
    logic [VALUE_W-1:0] ext;
    logic [VALUE_W-1:0] val;
    mask   = ~(16'hFFFF << n);
    ext    = $signed(v << (32'd16 - n)) >>> (32'd16 - n);
    r.fits = (ext == v);
    if (r.fits || !sat) begin
      val = v & mask;
    end else if (v[VALUE_W-1]) begin
      val = mask & ~(mask >> 1);
    end else begin
      val = mask >> 1;
    end
    r.field = val[FIELD_W-1:0];
    return r;
  endfunction

  // Narrow a 16-bit value into the instruction field for the given kind.
  function automatic pack_res_t pack_imm(input logic [VALUE_W-1:0] v,
                                         input logic [KIND_W-1:0] kind,
                                         input logic sat);
    pack_res_t r;
    case (kind)
      IM5:  r = pack_signed(v, 32'd5, sat);
      IM4:  r = pack_signed(v, 32'd4, sat);
      IM8:  r = pack_signed(v, 32'd8, sat);
      IM11: r = pack_signed(v, 32'd11, sat);
      IM3: begin
        // The 3-bit field lives in instruction bits 4:2.
        r       = pack_signed(v, 32'd3, sat);
        r.field = {r.field[FIELD_W-3:0], 2'b00};
      end
      IM_ZERO8: begin
        r.fits  = (v[15:8] == 8'h00);
        r.field = (r.fits || !sat) ? {3'b000, v[7:0]} : 11'h0FF;
      end
      IM_TO8: begin
        r.fits  = (v == 16'h0008);
        r.field = 11'h000;
      end
      IM0: begin
        r.fits  = (v == 16'h0000);
        r.field = 11'h000;
      end
      default: begin
        r.fits  = (v == 16'h0000);
        r.field = 11'h000;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_pack_if.sv
// Input and output valid/ready channels of the immediate packer.
interface imm_pack_if;
  import imm_pack_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [VALUE_W-1:0] in_value;
  logic [KIND_W-1:0]  in_kind;
  logic               out_valid;
  logic               out_ready;
  logic [FIELD_W-1:0] out_field;
  logic               out_fits;

  modport master (
    output in_valid, in_value, in_kind, out_ready,
    input  in_ready, out_valid, out_field, out_fits
  );

  modport slave (
    input  in_valid, in_value, in_kind, out_ready,
    output in_ready, out_valid, out_field, out_fits
  );

endinterface

// File: rtl/imm_pack_core.sv
// Combinational packer: value + kind -> narrow field and round-trip flag.
module imm_pack_core
  import imm_pack_pkg::*;
(
  input  logic [VALUE_W-1:0] value_i,
  input  logic [KIND_W-1:0]  kind_i,
  input  logic               sat_en_i,
  output logic [FIELD_W-1:0] field_o,
  output logic               fits_o
);

  pack_res_t res_s;

  // Evaluate the packing rules for the current stage-1 beat.
  always_comb begin
    res_s   = pack_imm(value_i, kind_i, sat_en_i);
    field_o = res_s.field;
    fits_o  = res_s.fits;
  end

endmodule

// File: rtl/imm_pack.sv
// Two-stage valid/ready immediate packer with sticky error flag and
// saturating out-of-range counter.
module imm_pack
  import imm_pack_pkg::*;
#(
  parameter int ERR_CNT_W = 8,
  parameter bit SAT_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  imm_pack_if.slave            bus,
  input  logic                 err_clr,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic               s1_valid_q, s1_valid_d;
  logic [VALUE_W-1:0] s1_value_q, s1_value_d;
  logic [KIND_W-1:0]  s1_kind_q,  s1_kind_d;
  logic               s2_valid_q, s2_valid_d;
  logic [FIELD_W-1:0] s2_field_q, s2_field_d;
  logic               s2_fits_q,  s2_fits_d;
  logic               err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic               s2_ready_s;
  logic               in_ready_s;
  logic               out_hs_s;
  logic [FIELD_W-1:0] core_field_s;
  logic               core_fits_s;

  imm_pack_core u_core (
    .value_i  (s1_value_q),
    .kind_i   (s1_kind_q),
    .sat_en_i (SAT_EN),
    .field_o  (core_field_s),
    .fits_o   (core_fits_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_field = s2_field_q;
  assign bus.out_fits  = s2_fits_q;
  assign err_sticky    = err_sticky_q;
  assign err_count     = err_count_q;

  // Handshake, stage advance and error accounting next-state.
  always_comb begin
    s2_ready_s = !s2_valid_q || bus.out_ready;
    in_ready_s = !s1_valid_q || s2_ready_s;
    out_hs_s   = s2_valid_q && bus.out_ready;

    if (in_ready_s) begin
      s1_valid_d = bus.in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (bus.in_valid && in_ready_s) begin
      s1_value_d = bus.in_value;
      s1_kind_d  = bus.in_kind;
    end else begin
      s1_value_d = s1_value_q;
      s1_kind_d  = s1_kind_q;
    end

    if (s2_ready_s) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    // Result registers only move when a beat advances, so a stalled
    // output stays stable.
    if (s1_valid_q && s2_ready_s) begin
      s2_field_d = core_field_s;
      s2_fits_d  = core_fits_s;
    end else begin
      s2_field_d = s2_field_q;
      s2_fits_d  = s2_fits_q;
    end

    // Clear wins over a same-cycle bad handshake.
    if (err_clr) begin
      err_sticky_d = 1'b0;
      err_count_d  = {ERR_CNT_W{1'b0}};
    end else if (out_hs_s && !s2_fits_q) begin
      err_sticky_d = 1'b1;
      if (err_count_q == {ERR_CNT_W{1'b1}}) begin
        err_count_d = err_count_q;
      end else begin
        err_count_d = err_count_q + ERR_CNT_W'(1);
      end
    end else begin
      err_sticky_d = err_sticky_q;
      err_count_d  = err_count_q;
    end
  end

  // Pipeline and error state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_value_q   <= 16'h0000;
      s1_kind_q    <= IM0;
      s2_valid_q   <= 1'b0;
      s2_field_q   <= 11'h000;
      s2_fits_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= {ERR_CNT_W{1'b0}};
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_value_q   <= s1_value_d;
      s1_kind_q    <= s1_kind_d;
      s2_valid_q   <= s2_valid_d;
      s2_field_q   <= s2_field_d;
      s2_fits_q    <= s2_fits_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// Bench for imm_pack: one truncating instance (8-bit counter) and one
// clamping instance (2-bit counter) share the same stimulus and are both
// checked against a range-arithmetic model and a beat scoreboard.
module tb_imm_pack;
  import imm_pack_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic        in_valid;
  logic [15:0] in_value;
  logic [2:0]  in_kind;
  logic        out_ready;

  logic        err_sticky0, err_sticky1;
  logic [7:0]  err_count0;
  logic [1:0]  err_count1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  imm_pack_if if0 ();
  imm_pack_if if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_value  = in_value;
  assign if0.in_kind   = in_kind;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_value  = in_value;
  assign if1.in_kind   = in_kind;
  assign if1.out_ready = out_ready;

  imm_pack #(.ERR_CNT_W(8), .SAT_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .err_clr(err_clr),
    .err_sticky(err_sticky0), .err_count(err_count0)
  );

  imm_pack #(.ERR_CNT_W(2), .SAT_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .err_clr(err_clr),
    .err_sticky(err_sticky1), .err_count(err_count1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: range test on the signed/unsigned value, clamp or mask.
  function automatic void model_pack(input logic [15:0] v, input logic [2:0] k, input bit sat,
                                     output logic [10:0] f, output bit fits);
    int sv, n, sh, lo, hi, val;
    sv = int'($signed(v));
    f = 11'h000; fits = 1'b0; n = 0; sh = 0; val = 0;
    case (k)
      IM5:  n = 5;
      IM4:  n = 4;
      IM8:  n = 8;
      IM11: n = 11;
      IM3:  begin n = 3; sh = 2; end
      IM_ZERO8: begin
        fits = (int'(v) < 256);
        val  = fits ? int'(v) : (sat ? 255 : int'(v) % 256);
        f    = 11'(val);
      end
      IM_TO8:  fits = (v == 16'd8);
      default: fits = (v == 16'd0);
    endcase
    if (n > 0) begin
      lo   = -(1 << (n - 1));
      hi   = (1 << (n - 1)) - 1;
      fits = (sv >= lo) && (sv <= hi);
      val  = sv;
      if (!fits && sat) val = (sv < 0) ? lo : hi;
      val  = val & ((1 << n) - 1);
      f    = 11'(val << sh);
    end
  endfunction

  typedef struct { logic [15:0] v; logic [2:0] k; } beat_t;
  beat_t       sb[$];
  beat_t       b;
  int          cnt0, cnt1;
  bit          st0, st1;
  bit          prev_stall;
  logic [10:0] pf0, pf1;
  logic        pfit0, pfit1;
  logic [10:0] e0f, e1f;
  bit          e0fit, e1fit;
  bit          hs;

  // Per-cycle comparison against the scoreboard and error model.
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      cnt0 = 0; cnt1 = 0; st0 = 1'b0; st1 = 1'b0; prev_stall = 1'b0;
    end else begin
      check("in_ready0", if0.in_ready, (sb.size() < 2) || out_ready);
      check("in_ready1", if1.in_ready, (sb.size() < 2) || out_ready);
      if (sb.size() == 0) begin
        check("valid_without_beat0", if0.out_valid, 1'b0);
        check("valid_without_beat1", if1.out_valid, 1'b0);
      end
      if (prev_stall) begin
        check("hold_valid", if0.out_valid, 1'b1);
        check("hold_field0", if0.out_field, pf0);
        check("hold_field1", if1.out_field, pf1);
        check("hold_fits0", if0.out_fits, pfit0);
        check("hold_fits1", if1.out_fits, pfit1);
      end
      check("err_count0", err_count0, cnt0);
      check("err_count1", err_count1, cnt1);
      check("err_sticky0", err_sticky0, st0);
      check("err_sticky1", err_sticky1, st1);
      hs = if0.out_valid && out_ready;
      e0fit = 1'b1;
      if (hs && sb.size() > 0) begin
        b = sb.pop_front();
        model_pack(b.v, b.k, 1'b0, e0f, e0fit);
        model_pack(b.v, b.k, 1'b1, e1f, e1fit);
        check("field0", if0.out_field, e0f);
        check("fits0", if0.out_fits, e0fit);
        check("valid1", if1.out_valid, 1'b1);
        check("field1", if1.out_field, e1f);
        check("fits1", if1.out_fits, e1fit);
      end
      if (err_clr) begin
        cnt0 = 0; cnt1 = 0; st0 = 1'b0; st1 = 1'b0;
      end else if (hs && !e0fit) begin
        st0 = 1'b1; st1 = 1'b1;
        if (cnt0 < 255) cnt0++;
        if (cnt1 < 3) cnt1++;
      end
      if (in_valid && if0.in_ready) sb.push_back('{v: in_value, k: in_kind});
      prev_stall = if0.out_valid && !out_ready;
      pf0 = if0.out_field; pf1 = if1.out_field;
      pfit0 = if0.out_fits; pfit1 = if1.out_fits;
    end
  end

  // Present one beat and hold it until accepted, with a cycle bound.
  task automatic send(input logic [15:0] v, input logic [2:0] k);
    int n;
    bit done;
    n = 0; done = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_value = v; in_kind = k;
    while (!done) begin
      @(negedge clk);
      done = if0.in_ready;
      n++;
      @(posedge clk); #1;
      if (!done && n > 200) begin
        n_checks++;
        $display("FAIL send_timeout: in_ready still 0 after %0d cycles, required 1", n);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Single beat through an idle pipeline with literal expectations.
  task automatic beat(input string name, input logic [15:0] v, input logic [2:0] k,
                      input logic [10:0] f0, input logic [10:0] f1, input logic fit);
    @(posedge clk); #1;
    in_valid = 1'b1; in_value = v; in_kind = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_lat1"}, if0.out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, if0.out_valid, 1'b1);
    check({name, "_field0"}, if0.out_field, f0);
    check({name, "_field1"}, if1.out_field, f1);
    check({name, "_fits0"}, if0.out_fits, fit);
    check({name, "_fits1"}, if1.out_fits, fit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [10:0] mf;
  bit          mfit;
  logic [10:0] held;
  int          r;

  initial begin
    rst = 1'b0; err_clr = 1'b0; in_valid = 1'b0; in_value = 16'h0000;
    in_kind = IM0; out_ready = 1'b1;

    // Pin the model on hand-worked cases.
    model_pack(16'h0010, IM5, 1'b1, mf, mfit);
    check("model_im5_sat", {mf, mfit}, {11'h00F, 1'b0});
    model_pack(16'hFE00, IM8, 1'b1, mf, mfit);
    check("model_im8_min", {mf, mfit}, {11'h080, 1'b0});
    model_pack(16'h0003, IM3, 1'b0, mf, mfit);
    check("model_im3", {mf, mfit}, {11'h00C, 1'b1});

    #3;
    check("rst_in_ready", if0.in_ready, 1'b1);
    check("rst_out_valid", if0.out_valid, 1'b0);
    check("rst_out_field", if0.out_field, 11'h000);
    check("rst_out_fits", if0.out_fits, 1'b0);
    check("rst_err_count", err_count0, 8'h00);
    check("rst_err_sticky", err_sticky0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    beat("im5_neg",   16'hFFF0, IM5, 11'h010, 11'h010, 1'b1);
    beat("im5_pos",   16'h0010, IM5, 11'h010, 11'h00F, 1'b0);
    @(posedge clk); @(negedge clk);
    check("err_after_one", err_count0, 8'd1);
    beat("im3",       16'h0003, IM3, 11'h00C, 11'h00C, 1'b1);
    beat("to8_ok",    16'h0008, IM_TO8, 11'h000, 11'h000, 1'b1);
    beat("to8_bad",   16'h0009, IM_TO8, 11'h000, 11'h000, 1'b0);
    beat("im8_pos",   16'h0200, IM8, 11'h000, 11'h07F, 1'b0);
    beat("im8_neg",   16'hFE00, IM8, 11'h000, 11'h080, 1'b0);
    beat("zero8_big", 16'h0100, IM_ZERO8, 11'h000, 11'h0FF, 1'b0);
    @(posedge clk); @(negedge clk);
    check("err_count_5", err_count0, 8'd5);
    check("err_count_sat", err_count1, 2'd3);
    check("err_sticky_set", err_sticky1, 1'b1);

    // Sixth bad beat with clear on the same cycle as its handshake.
    @(posedge clk); #1;
    in_valid = 1'b1; in_value = 16'h0010; in_kind = IM5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("clr_count0", err_count0, 8'd0);
    check("clr_count1", err_count1, 2'd0);
    check("clr_sticky0", err_sticky0, 1'b0);
    check("clr_sticky1", err_sticky1, 1'b0);

    // Stall: two beats fill the pipe, then two more wait behind it.
    out_ready = 1'b0;
    send(16'h0005, IM5);
    send(16'h0006, IM5);
    @(negedge clk);
    check("stall_in_ready", if0.in_ready, 1'b0);
    check("stall_out_valid", if0.out_valid, 1'b1);
    check("stall_first_field", if0.out_field, 11'h005);
    held = if0.out_field;
    fork
      begin
        send(16'h0007, IM5);
        send(16'hFFFF, IM5);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_held_field", if0.out_field, held);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("stall_drained", sb.size(), 0);

    // Randomised traffic: first mostly ready, then mostly stalled.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 3);
      case (r)
        0: in_value = 16'($urandom);
        1: in_value = 16'($urandom_range(0, 700)) - 16'd350;
        2: in_value = 16'($urandom_range(0, 9));
        default: in_value = {8'hFF, 8'($urandom)};
      endcase
      in_kind  = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 3);
      out_ready = (c < 300) ? (r != 0) : (r == 0);
      err_clr  = ($urandom_range(0, 40) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("random_drained", sb.size(), 0);

    // Reset with both stages holding beats.
    out_ready = 1'b0;
    send(16'h0001, IM8);
    send(16'h0002, IM8);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid0", if0.out_valid, 1'b0);
    check("mid_rst_valid1", if1.out_valid, 1'b0);
    check("mid_rst_in_ready", if0.in_ready, 1'b1);
    check("mid_rst_err", err_count0, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_valid", if0.out_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_pack.md
Name: imm_pack

Overview:
- Inverse of the decode-side immediate extender: takes a 16-bit value plus an immediate-kind code and produces the narrow instruction immediate field (11-bit container).
- Flags values that do not survive a narrow-then-extend round trip.
- Used by the instruction patch/assembly path (boot loader, serial program writer) before instruction words are written to memory.
- Two-stage valid/ready pipeline; sticky error flag and saturating error counter.

Parameters:
- ERR_CNT_W, 8, width of the saturating out-of-range counter.
- SAT_EN, 0; 0 = truncate out-of-range values, 1 = clamp to the field min/max.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline can accept a beat.
- in_value  in  16  full-width immediate.
- in_kind  in  3  immediate kind: IM0, IM3, IM4, IM5, IM8, IM11, IM_TO8, IM_Zero8 (codes from config.v).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_field  out  11  packed field, right-aligned; unused upper bits are 0.
- out_fits  out  1  in_value is exactly representable in this kind.
- err_sticky  out  1  set by any out-of-range beat that is accepted downstream.
- err_count  out  ERR_CNT_W  saturating count of out-of-range beats.
- err_clr  in  1  synchronous clear of err_sticky and err_count.

Behaviour:
- Reset (rst=0, async): both stage-valid bits=0; out_field=0, out_fits=0, err_sticky=0, err_count=0. Ready is combinational, so in_ready=1 during reset.
- Stage 1 registers {in_value, in_kind} on in_valid && in_ready.
- Stage 2 registers the packed result.
- Latency: exactly 2 cycles from accept to out_valid when not stalled. Throughput 1 beat/cycle.
- Handshake:
  - s2_ready = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_ready.
  - No combinational path from in_valid to out_valid.
  - out_* are held stable while out_valid && !out_ready.
- Packing (v = in_value); fits means the upper bits equal the field sign bit:
  - IM5: field[4:0]=v[4:0]; fits iff v[15:5] are all equal to v[4].
  - IM4: field[3:0]=v[3:0]; fits iff v[15:4] are all equal to v[3].
  - IM8: field[7:0]=v[7:0]; fits iff v[15:8] are all equal to v[7].
  - IM11: field[10:0]=v[10:0]; fits iff v[15:11] are all equal to v[10].
  - IM3: field[4:2]=v[2:0], field[1:0]=0 (field sits in instruction bits 4:2); fits iff v[15:3] are all equal to v[2].
  - IM_Zero8: field[7:0]=v[7:0]; fits iff v[15:8]==0.
  - IM_TO8: field=0; fits iff v==16'h0008.
  - IM0 and any undefined code: field=0; fits iff v==0.
- Saturation (SAT_EN=1, fits=0):
  - Signed kinds clamp to the N-bit max (0 followed by ones) if v is positive (v[15]=0), otherwise to the min (1 followed by zeros).
  - IM_Zero8 clamps to 8'hFF.
  - IM_TO8, IM0 and default keep field=0.
  - out_fits stays 0 either way.
- Error accounting: on an output handshake (out_valid && out_ready) with out_fits=0, set err_sticky and increment err_count.
  - err_count saturates at all-ones and does not wrap.
- err_clr has priority over a simultaneous increment: the counter becomes 0, not 1, and the sticky flag is cleared.
- Reset mid-operation drops in-flight beats with no output handshake.

Decomposition:
- Shared package / config.v:
  - the IM* kind codes, reused as-is with no new encodings;
  - the field-width constant (11);
  - a packing-function include.
- One natural combinational sub-module, imm_pack_core (value, kind, sat_en → field, fits). The pipeline, handshake and counters stay in imm_pack.

Test Plan:
- IM5 with v=16'hFFF0 -> field=11'h010, fits=1; v=16'h0010 -> field=11'h010, fits=0, err_count=1.
- IM3 with v=16'h0003 -> field=11'h00C, fits=1; IM_TO8 with v=8 -> fits=1, and v=9 -> fits=0, field=0.
- SAT_EN=1, IM8 with v=16'h0200 -> field=11'h07F; v=16'hFE00 -> field=11'h080. IM_Zero8 with v=16'h0100 -> field=11'h0FF, fits=0.
- Stream of 4 beats with out_ready=0 for 3 cycles:
  - in_ready drops after 2 beats are accepted;
  - outputs stay held while stalled;
  - all 4 beats emerge in order with no loss or duplication.
- ERR_CNT_W=2, 5 out-of-range beats -> err_count=3; err_clr asserted in the same cycle as a 6th bad handshake -> err_count=0, err_sticky=0.
- rst asserted while both stages are valid -> out_valid=0 immediately; no spurious handshake after release.
